veririsc_controller: RTL and testbench
======================================

Name: veririsc_controller

Overview:
- Instruction sequencer for the 8-bit CPU.
- An 8-phase counter walks every instruction through fetch and execute. Combinational decode of the phase, the 3-bit opcode and the accumulator-zero flag drives every datapath strobe: memory address mux, memory read/write, IR load, PC increment/load, accumulator load, data-bus enable.
- Also owns halt/resume and a global stall (enable).
- Sits between the instruction register and the ALU, PC, accumulator and memory.

Parameters:
- OPCODE_W, 3, opcode width. Fixed encoding; only 3 is legal.

Ports:
- clk  input  1  rising-edge clock
- rst_  input  1  asynchronous, active-low reset
- enable  input  1  1 = phase advances; 0 = stall
- resume  input  1  level; leaves the halted state
- opcode  input  OPCODE_W  from IR: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP
- zero  input  1  accumulator-is-zero flag from the ALU
- sel  output  1  1 = memory address from PC, 0 = from IR operand
- rd  output  1  memory read
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment PC
- ld_pc  output  1  load PC from IR operand
- ld_ac  output  1  load accumulator from ALU output
- wr  output  1  memory write
- data_e  output  1  drive accumulator onto data bus
- halt  output  1  CPU halted
- phase  output  3  current phase, for debug

Behaviour:
- State registers:
  - phase_q[2:0]
  - halted_q
  - Only these are clocked; all outputs are combinational from phase_q, halted_q, opcode, zero and enable.
- Reset (rst_=0, asynchronous, any time, including mid-instruction or while halted):
  - phase_q=0, halted_q=0
  - Outputs: sel=1, all other strobes 0, halt=0, phase=0.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase decode, with halted_q=0 (strobes not listed are 0):
  - 0 INST_ADDR: sel=1
  - 1 INST_FETCH: sel=1, rd=1
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1
  - 3 IDLE: sel=1, rd=1, ld_ir=1
  - 4 OP_ADDR: inc_pc=1; halt=(opcode==HLT)
  - 5 OP_FETCH: rd=ALUOP
  - 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO)
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO)
- Phase advance:
  - On each clk edge with enable=1 and halted_q=0, phase_q <= phase_q+1; wraps 7 -> 0.
  - One instruction takes 8 cycles.
- Halt entry:
  - Edge with enable=1, phase_q=4, opcode==HLT: halted_q <= 1 and phase_q holds at 4.
  - The single OP_ADDR cycle before entry still asserts inc_pc=1, so the PC points at the next instruction.
- Halted (halted_q=1):
  - halt=1, phase=4, all other strobes 0, including sel and inc_pc.
  - Phase does not advance.
- Resume:
  - Edge with halted_q=1, enable=1, resume=1: halted_q <= 0, phase_q <= 5.
  - Phases 5-7 then run with opcode HLT and have no datapath effect; phase 0 follows.
  - resume is ignored when not halted, and ignored when enable=0.
- Stall (enable=0):
  - phase_q and halted_q hold.
  - ld_ir, inc_pc, ld_pc, ld_ac and wr are forced to 0.
  - sel, rd, data_e and halt keep their decoded values.
  - On return of enable, the phase's full decode reappears before the phase advances, so each strobe fires exactly once per phase cycle with enable=1.
- zero is sampled combinationally only in phase 6; a change in any other phase has no effect.
- Opcode changes outside phases 2/3 are not expected; the decode follows opcode combinationally regardless.

Test Plan:
- Reset mid-instruction: drive rst_=0 asynchronously while phase=5 with opcode=ADD -> phase=0 and sel=1 immediately, all other strobes 0; after release, phases 0..7 restart.
- ADD (010), enable=1 for 8 cycles -> phase 0..7:
  - sel=1 in 0-3; rd=1 in 1,2,3,5,6,7; ld_ir=1 in 2,3; inc_pc=1 in 4 only; ld_ac=1 in 7 only; wr, ld_pc, data_e never asserted.
- SKZ (001):
  - zero=1 -> inc_pc=1 in phases 4 and 6.
  - zero=0 -> inc_pc=1 in phase 4 only.
  - Toggling zero in phase 5 has no effect.
- JMP (111) -> ld_pc=1 in phases 6 and 7. STO (110) -> data_e=1 in phases 6 and 7, wr=1 in phase 7 only; rd=0 and ld_ac=0 in phases 5-7.
- HLT (000):
  - Phase 4: halt=1 and inc_pc=1 for one cycle.
  - Next 10 cycles: phase=4, halt=1, inc_pc=0, sel=0.
  - resume=1 for one cycle with enable=1 -> next cycle phase=5 and halt=0; phase=0 three cycles after that.
- Stall at phase 2 (enable=0 for 5 cycles) -> phase stays 2, ld_ir=0, sel=1, rd=1. After enable=1: ld_ir=1 for exactly the one cycle before phase 3.

Source files
------------

// File: rtl/veririsc_controller.sv
// Instruction sequencer for the 8-bit CPU: an 8-phase fetch/execute walk plus
// halt/resume and a global stall. All datapath strobes are decoded combinationally.
module veririsc_controller #(
  parameter int OPCODE_W = 3
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                enable,
  input  logic                resume,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e,
  output logic                halt,
  output logic [2:0]          phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase = phase_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: halted entry freezes phase at OP_ADDR; resume re-enters at OP_FETCH.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (enable) begin
      if (halted_q) begin
        if (resume) begin
          halted_d = 1'b0;
          phase_d  = OP_FETCH;
        end
      end else if (phase_q == OP_ADDR && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
    // Stall masks only the state-changing strobes; bus-facing ones stay decoded.
    if (!enable) begin
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
    end
  end

endmodule

// File: tb/tb_veririsc_controller.sv
// Bench for veririsc_controller: directed instruction walks with literal strobe masks,
// then random stimulus checked every cycle against a phase/halt model.
`timescale 1ns/1ps
module tb_veririsc_controller;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       enable = 1'b0;
  logic       resume = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;
  logic check_on = 1'b0;

  // model state
  int   m_phase = 0;
  logic m_halted = 1'b0;

  // per-phase masks of observed strobes (bit p = strobe seen high at phase p)
  logic [7:0] sel_m, rd_m, ldir_m, inc_m, ldpc_m, ldac_m, wr_m, de_m, halt_m;

  veririsc_controller #(.OPCODE_W(3)) dut (
    .clk(clk), .rst_(rst_), .enable(enable), .resume(resume), .opcode(opcode),
    .zero(zero), .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // behavioural model: one instruction = 8 phases; HLT parks at 4 until resume
  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (enable) begin
      if (m_halted) begin
        if (resume) begin
          m_halted = 1'b0;
          m_phase  = 5;
        end
      end else if (m_phase == 4 && opcode == 3'd0) begin
        m_halted = 1'b1;
      end else begin
        m_phase = (m_phase + 1) % 8;
      end
    end
  end

  // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,phase[2:0]}
  function automatic logic [11:0] expect_out(int ph, logic hlt, logic [2:0] op,
                                             logic z, logic en);
    logic s, r, li, ip, lp, la, w, de, h, alu;
    alu = (op >= 3'd2 && op <= 3'd5);
    s = 0; r = 0; li = 0; ip = 0; lp = 0; la = 0; w = 0; de = 0; h = 0;
    if (hlt) begin
      h = 1;
    end else begin
      s  = (ph < 4);
      r  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      li = (ph == 2 || ph == 3);
      ip = (ph == 4) || (ph == 6 && op == 3'd1 && z);
      lp = (ph >= 6 && op == 3'd7);
      la = (ph == 7 && alu);
      w  = (ph == 7 && op == 3'd6);
      de = (ph >= 6 && op == 3'd6);
      h  = (ph == 4 && op == 3'd0);
    end
    if (!en) begin
      li = 0; ip = 0; lp = 0; la = 0; w = 0;
    end
    return {s, r, li, ip, lp, la, w, de, h, 3'(ph)};
  endfunction

  // scoreboard compare, every cycle while enabled, away from the active edge
  always @(negedge clk) begin
    if (check_on && rst_) begin
      logic [11:0] act, exp_v;
      act   = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
      exp_v = expect_out(m_phase, m_halted, opcode, zero, enable);
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL cycle_model t=%0t: got %b, expected %b", $time, act, exp_v);
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic clear_masks();
    sel_m = 0; rd_m = 0; ldir_m = 0; inc_m = 0; ldpc_m = 0;
    ldac_m = 0; wr_m = 0; de_m = 0; halt_m = 0;
  endtask

  // One clock: inputs applied just after posedge, outputs recorded at negedge.
  task automatic run_cycle(input logic en, input logic res, input logic [2:0] op,
                           input logic z);
    enable = en; resume = res; opcode = op; zero = z;
    @(negedge clk);
    sel_m[m_phase]  |= sel;   rd_m[m_phase]   |= rd;
    ldir_m[m_phase] |= ld_ir; inc_m[m_phase]  |= inc_pc;
    ldpc_m[m_phase] |= ld_pc; ldac_m[m_phase] |= ld_ac;
    wr_m[m_phase]   |= wr;    de_m[m_phase]   |= data_e;
    halt_m[m_phase] |= halt;
    @(posedge clk);
    #1;
  endtask

  // Eight enabled cycles from phase 0; zvec[p] is the zero flag during phase p.
  task automatic run_instr(input logic [2:0] op, input logic [7:0] zvec);
    clear_masks();
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, op, zvec[m_phase]);
  endtask

  initial begin
    logic [7:0] bad;
    clear_masks();
    #2;
    check("reset_phase", 32'(phase), 0);
    check("reset_strobes", 32'({sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}),
          32'h100);
    #1 rst_ = 1'b1;
    @(posedge clk);
    #1;
    check_on = 1'b1;

    // ADD walk
    run_instr(3'd2, 8'h00);
    check("add_sel", 32'(sel_m), 32'h0F);
    check("add_rd", 32'(rd_m), 32'hEE);
    check("add_ld_ir", 32'(ldir_m), 32'h0C);
    check("add_inc_pc", 32'(inc_m), 32'h10);
    check("add_ld_ac", 32'(ldac_m), 32'h80);
    check("add_unused", 32'({wr_m, ldpc_m, de_m}), 0);

    // SKZ variants
    run_instr(3'd1, 8'hFF);
    check("skz_zero1_inc", 32'(inc_m), 32'h50);
    run_instr(3'd1, 8'h00);
    check("skz_zero0_inc", 32'(inc_m), 32'h10);
    run_instr(3'd1, 8'h20);
    check("skz_zero_ph5_only", 32'(inc_m), 32'h10);

    // JMP and STO
    run_instr(3'd7, 8'h00);
    check("jmp_ld_pc", 32'(ldpc_m), 32'hC0);
    run_instr(3'd6, 8'h00);
    check("sto_data_e", 32'(de_m), 32'hC0);
    check("sto_wr", 32'(wr_m), 32'h80);
    check("sto_rd", 32'(rd_m), 32'h0E);
    check("sto_ld_ac", 32'(ldac_m), 0);

    // HLT: phases 0..4, then parked
    clear_masks();
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    check("hlt_halt_ph4", 32'(halt_m), 32'h10);
    check("hlt_inc_ph4", 32'(inc_m), 32'h10);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 1'b0, 3'd0, 1'b0);
      if (phase !== 3'd4 || halt !== 1'b1 || inc_pc !== 1'b0 || sel !== 1'b0) bad++;
    end
    check("halted_10_cycles_bad", 32'(bad), 0);
    run_cycle(1'b0, 1'b1, 3'd0, 1'b0);   // resume ignored while stalled
    run_cycle(1'b1, 1'b1, 3'd0, 1'b0);
    check("resume_phase", 32'(phase), 5);
    check("resume_halt", 32'(halt), 0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    check("resume_wrap_phase", 32'(phase), 0);

    // stall at phase 2
    run_cycle(1'b1, 1'b0, 3'd2, 1'b0);
    run_cycle(1'b1, 1'b0, 3'd2, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      enable = 1'b0;
      @(negedge clk);
      if (phase !== 3'd2 || ld_ir !== 1'b0 || sel !== 1'b1 || rd !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    check("stall_ph2_bad", 32'(bad), 0);
    enable = 1'b1;
    @(negedge clk);
    check("unstall_ld_ir", 32'(ld_ir), 1);
    check("unstall_phase", 32'(phase), 2);
    @(posedge clk);
    #1;
    check("after_unstall_phase", 32'(phase), 3);

    // async reset mid-instruction at phase 5
    for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b0, 3'd2, 1'b0);
    check("pre_reset_phase", 32'(phase), 5);
    rst_ = 1'b0;
    #1;
    check("async_reset_phase", 32'(phase), 0);
    check("async_reset_strobes",
          32'({sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}), 32'h100);
    #1 rst_ = 1'b1;
    @(posedge clk);
    #1;
    run_instr(3'd2, 8'h00);
    check("post_reset_rd", 32'(rd_m), 32'hEE);

    // random stimulus; opcode only changes while the IR is loading
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      op = opcode;
      if (m_phase == 2) op = 3'($urandom_range(0, 7));
      run_cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), op,
                1'($urandom_range(0, 1)));
    end

    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
